// File: rtl/rssb_control_hs.sv
// -----------------------------------------------------------------------------
// rssb_control_hs
//
// Control FSM for the RSSB datapath over a request/acknowledge memory port.
// Each instruction runs FETCH (read OP1), READ (read MDR), EXEC (write the ALU
// result to memory and ACC) and UPDATE (advance PC by 1 or 2). Every memory
// state waits for mem_ack, so memory latency may vary. An access left
// unacknowledged for too long drops the FSM into a sticky FAULT state.
//
// Parameters
//   TIMEOUT     maximum wait cycles per memory access (0 = no timeout)
//   CNT_W       width of the retired-instruction counter
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   run         level: execute continuously while high
//   step        pulse: in HALT with run low, execute one instruction
//   mem_ack     memory acknowledge for the current request
//   neg         ALU result (MDR - ACC) is negative
//   mem_req     memory access request
//   sel_mem     address select, 0 = PC, 1 = OP1
//   write_mem   memory write enable (qualifies mem_req)
//   write_op1   load OP1 from read data (ack-qualified)
//   write_mdr   load MDR from read data (ack-qualified)
//   write_acc   load ACC from ALU result (ack-qualified)
//   write_pc    load PC
//   sel_pc      PC increment select, 0 = PC+1, 1 = PC+2
//   halted      FSM is in HALT
//   fault       access timeout occurred, sticky until reset
//   instr_count retired instructions, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module rssb_control_hs #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             mem_ack,
    input  logic             neg,
    output logic             mem_req,
    output logic             sel_mem,
    output logic             write_mem,
    output logic             write_op1,
    output logic             write_mdr,
    output logic             write_acc,
    output logic             write_pc,
    output logic             sel_pc,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    // Wait counter only needs to reach TIMEOUT; keep at least one bit.
    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_MAX   = {WAIT_W{1'b1}};
    localparam bit TIMEOUT_EN = (TIMEOUT > 0);

    typedef enum logic [2:0] {
        ST_HALT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_READ   = 3'd2,
        ST_EXEC   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              step_mode_q, step_mode_d;
    logic              neg_q, neg_d;
    logic [CNT_W-1:0]  instr_count_q, instr_count_d;

    // Moore outputs are registered: computed from the next state so they
    // line up exactly with the state register.
    logic mem_req_q,   mem_req_d;
    logic sel_mem_q,   sel_mem_d;
    logic write_mem_q, write_mem_d;
    logic write_pc_q,  write_pc_d;
    logic sel_pc_q,    sel_pc_d;
    logic halted_q,    halted_d;
    logic fault_q,     fault_d;

    logic in_mem_state;

    assign in_mem_state = (state_q == ST_FETCH) || (state_q == ST_READ) ||
                          (state_q == ST_EXEC);

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        step_mode_d   = step_mode_q;
        neg_d         = neg_q;
        instr_count_d = instr_count_q;

        case (state_q)
            ST_HALT: begin
                if (run) begin
                    state_d = ST_FETCH;
                end else if (step) begin
                    state_d     = ST_FETCH;
                    step_mode_d = 1'b1;
                end
            end
            ST_FETCH: if (mem_ack) state_d = ST_READ;
            ST_READ:  if (mem_ack) state_d = ST_EXEC;
            ST_EXEC: begin
                if (mem_ack) begin
                    neg_d   = neg;
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                instr_count_d = instr_count_q + CNT_W'(1);
                if (step_mode_q || !run) begin
                    state_d     = ST_HALT;
                    step_mode_d = 1'b0;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_HALT;
        endcase

        // Unacknowledged access: fault once the limit has already been
        // waited out; otherwise count the wait, saturating.
        if (in_mem_state && !mem_ack) begin
            if (TIMEOUT_EN && (wait_cnt_q == WAIT_LIMIT)) begin
                state_d = ST_FAULT;
            end else if (wait_cnt_q != WAIT_MAX) begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end

        // Every memory state starts its access with a fresh wait count.
        if ((state_d != state_q) &&
            ((state_d == ST_FETCH) || (state_d == ST_READ) || (state_d == ST_EXEC))) begin
            wait_cnt_d = '0;
        end

        mem_req_d   = (state_d == ST_FETCH) || (state_d == ST_READ) || (state_d == ST_EXEC);
        sel_mem_d   = (state_d == ST_READ) || (state_d == ST_EXEC);
        write_mem_d = (state_d == ST_EXEC);
        write_pc_d  = (state_d == ST_UPDATE);
        sel_pc_d    = (state_d == ST_UPDATE) && neg_d;
        halted_d    = (state_d == ST_HALT);
        fault_d     = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_HALT;
            wait_cnt_q    <= '0;
            step_mode_q   <= 1'b0;
            neg_q         <= 1'b0;
            instr_count_q <= '0;
            mem_req_q     <= 1'b0;
            sel_mem_q     <= 1'b0;
            write_mem_q   <= 1'b0;
            write_pc_q    <= 1'b0;
            sel_pc_q      <= 1'b0;
            halted_q      <= 1'b1;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            step_mode_q   <= step_mode_d;
            neg_q         <= neg_d;
            instr_count_q <= instr_count_d;
            mem_req_q     <= mem_req_d;
            sel_mem_q     <= sel_mem_d;
            write_mem_q   <= write_mem_d;
            write_pc_q    <= write_pc_d;
            sel_pc_q      <= sel_pc_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
        end
    end

    // Register loads fire only on the acknowledged cycle of their own state.
    assign write_op1 = (state_q == ST_FETCH) && mem_ack;
    assign write_mdr = (state_q == ST_READ)  && mem_ack;
    assign write_acc = (state_q == ST_EXEC)  && mem_ack;

    assign mem_req     = mem_req_q;
    assign sel_mem     = sel_mem_q;
    assign write_mem   = write_mem_q;
    assign write_pc    = write_pc_q;
    assign sel_pc      = sel_pc_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_rssb_control_hs.sv
// -----------------------------------------------------------------------------
// tb_rssb_control_hs
//
// Directed bench for rssb_control_hs (TIMEOUT=4, CNT_W=2). A table of per-cycle
// records gives the inputs for one clock cycle and the outputs expected in
// that cycle; inputs change on the falling edge and outputs are compared 1ns
// later. Hand-written sequences cover reset behaviour.
// -----------------------------------------------------------------------------
module tb_rssb_control_hs;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       mem_ack = 1'b0;
    logic       neg = 1'b0;
    logic       mem_req, sel_mem, write_mem, write_op1, write_mdr, write_acc;
    logic       write_pc, sel_pc, halted, fault;
    logic [1:0] instr_count;

    always #5 clk = ~clk;

    rssb_control_hs #(.TIMEOUT(4), .CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .step       (step),
        .mem_ack    (mem_ack),
        .neg        (neg),
        .mem_req    (mem_req),
        .sel_mem    (sel_mem),
        .write_mem  (write_mem),
        .write_op1  (write_op1),
        .write_mdr  (write_mdr),
        .write_acc  (write_acc),
        .write_pc   (write_pc),
        .sel_pc     (sel_pc),
        .halted     (halted),
        .fault      (fault),
        .instr_count(instr_count)
    );

    // Output vector order:
    // {mem_req, sel_mem, write_mem, write_op1, write_mdr, write_acc,
    //  write_pc, sel_pc, halted, fault}
    logic [9:0] out_vec;
    assign out_vec = {mem_req, sel_mem, write_mem, write_op1, write_mdr,
                      write_acc, write_pc, sel_pc, halted, fault};

    localparam logic [9:0] V_HALT = 10'b0000000010;
    localparam logic [9:0] V_F0   = 10'b1000000000;
    localparam logic [9:0] V_FA   = 10'b1001000000;
    localparam logic [9:0] V_R0   = 10'b1100000000;
    localparam logic [9:0] V_RA   = 10'b1100100000;
    localparam logic [9:0] V_E0   = 10'b1110000000;
    localparam logic [9:0] V_EA   = 10'b1110010000;
    localparam logic [9:0] V_U0   = 10'b0000001000;
    localparam logic [9:0] V_U1   = 10'b0000001100;
    localparam logic [9:0] V_FLT  = 10'b0000000001;

    typedef struct {
        logic       run;
        logic       step;
        logic       ack;
        logic       neg;
        logic [9:0] exp_out;
        logic [1:0] exp_cnt;
        string      name;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic s, input logic a, input logic n,
                       input logic [9:0] eo, input logic [1:0] ec, input string nm);
        vec_t v;
        v.run = r; v.step = s; v.ack = a; v.neg = n;
        v.exp_out = eo; v.exp_cnt = ec; v.name = nm;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    initial begin
        // run step ack neg  expected      cnt
        // Free run, zero-wait memory; neg=1 only on the first EXEC ack.
        add(1, 0, 1, 0, V_HALT, 2'd0, "run_halt");
        add(1, 0, 1, 0, V_FA,   2'd0, "i0_fetch");
        add(1, 0, 1, 0, V_RA,   2'd0, "i0_read");
        add(1, 0, 1, 1, V_EA,   2'd0, "i0_exec_neg1");
        add(1, 0, 1, 0, V_U1,   2'd0, "i0_update_pc2");
        add(1, 0, 1, 0, V_FA,   2'd1, "i1_fetch");
        add(1, 0, 1, 0, V_RA,   2'd1, "i1_read");
        add(1, 0, 1, 0, V_EA,   2'd1, "i1_exec_neg0");
        add(1, 0, 1, 1, V_U0,   2'd1, "i1_update_pc1");
        add(1, 0, 1, 0, V_FA,   2'd2, "i2_fetch");
        add(1, 0, 1, 0, V_RA,   2'd2, "i2_read");
        add(1, 0, 1, 0, V_EA,   2'd2, "i2_exec");
        add(1, 0, 1, 0, V_U0,   2'd2, "i2_update");
        // Three wait cycles in FETCH: 7-cycle instruction, count wraps 3->0.
        add(1, 0, 0, 0, V_F0,   2'd3, "i3_fetch_w1");
        add(1, 0, 0, 0, V_F0,   2'd3, "i3_fetch_w2");
        add(1, 0, 0, 0, V_F0,   2'd3, "i3_fetch_w3");
        add(1, 0, 1, 0, V_FA,   2'd3, "i3_fetch_ack");
        add(1, 0, 1, 0, V_RA,   2'd3, "i3_read");
        add(1, 0, 1, 0, V_EA,   2'd3, "i3_exec");
        add(1, 0, 1, 0, V_U0,   2'd3, "i3_update");
        // run dropped during EXEC: instruction completes, then HALT.
        add(1, 0, 1, 0, V_FA,   2'd0, "wrap_fetch");
        add(1, 0, 1, 0, V_RA,   2'd0, "i4_read");
        add(0, 0, 1, 0, V_EA,   2'd0, "i4_exec_run0");
        add(0, 0, 1, 0, V_U0,   2'd0, "i4_update_run0");
        add(0, 0, 1, 0, V_HALT, 2'd1, "halt_after_run0");
        add(0, 0, 1, 0, V_HALT, 2'd1, "halt_stays");
        // Single step; extra step pulses during execution are ignored.
        add(0, 1, 1, 0, V_HALT, 2'd1, "step_pulse");
        add(0, 1, 1, 0, V_FA,   2'd1, "step_fetch");
        add(0, 0, 1, 0, V_RA,   2'd1, "step_read");
        add(0, 1, 1, 0, V_EA,   2'd1, "step_exec");
        add(0, 0, 1, 0, V_U0,   2'd1, "step_update");
        add(0, 0, 1, 0, V_HALT, 2'd2, "step_done");
        add(0, 0, 1, 0, V_HALT, 2'd2, "step_one_only");
        // Ack exactly on READ cycle index 4: accepted, no fault.
        add(1, 0, 1, 0, V_HALT, 2'd2, "to_halt");
        add(1, 0, 1, 0, V_FA,   2'd2, "to_fetch");
        add(1, 0, 0, 0, V_R0,   2'd2, "to_read_c0");
        add(1, 0, 0, 0, V_R0,   2'd2, "to_read_c1");
        add(1, 0, 0, 0, V_R0,   2'd2, "to_read_c2");
        add(1, 0, 0, 0, V_R0,   2'd2, "to_read_c3");
        add(1, 0, 1, 0, V_RA,   2'd2, "to_read_c4_ack");
        add(1, 0, 1, 0, V_EA,   2'd2, "to_exec");
        add(1, 0, 1, 0, V_U0,   2'd2, "to_update");
        // Ack never arrives in READ: FAULT five cycles after entry, sticky.
        add(1, 0, 1, 0, V_FA,   2'd3, "flt_fetch");
        add(1, 0, 0, 0, V_R0,   2'd3, "flt_read_c0");
        add(1, 0, 0, 0, V_R0,   2'd3, "flt_read_c1");
        add(1, 0, 0, 0, V_R0,   2'd3, "flt_read_c2");
        add(1, 0, 0, 0, V_R0,   2'd3, "flt_read_c3");
        add(1, 0, 0, 0, V_R0,   2'd3, "flt_read_c4");
        add(1, 0, 0, 0, V_FLT,  2'd3, "fault_entered");
        add(1, 1, 1, 0, V_FLT,  2'd3, "fault_sticky1");
        add(1, 0, 1, 0, V_FLT,  2'd3, "fault_sticky2");

        // Reset values while rst is low.
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("reset_outputs", {6'd0, out_vec}, {6'd0, V_HALT});
            chk("reset_count", {14'd0, instr_count}, 16'd0);
        end
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            run = vq[i].run; step = vq[i].step;
            mem_ack = vq[i].ack; neg = vq[i].neg;
            #1;
            $display("vec %0d %s: run=%b step=%b ack=%b neg=%b out=%b cnt=%0d",
                     i, vq[i].name, run, step, mem_ack, neg, out_vec, instr_count);
            chk({vq[i].name, "_out"}, {6'd0, out_vec}, {6'd0, vq[i].exp_out});
            chk({vq[i].name, "_cnt"}, {14'd0, instr_count}, {14'd0, vq[i].exp_cnt});
        end

        // Reset clears the sticky fault and the counter.
        @(negedge clk);
        rst = 1'b0;
        #1;
        $display("seq reset_from_fault: out=%b cnt=%0d", out_vec, instr_count);
        chk("fault_cleared_out", {6'd0, out_vec}, {6'd0, V_HALT});
        chk("fault_cleared_cnt", {14'd0, instr_count}, 16'd0);

        // Asynchronous reset in the middle of EXEC.
        @(negedge clk);
        rst = 1'b1; run = 1'b1; step = 1'b0; mem_ack = 1'b1; neg = 1'b1;
        @(negedge clk); #1;
        chk("async_fetch", {6'd0, out_vec}, {6'd0, V_FA});
        @(negedge clk); #1;
        chk("async_read", {6'd0, out_vec}, {6'd0, V_RA});
        @(negedge clk); #1;
        chk("async_exec", {6'd0, out_vec}, {6'd0, V_EA});
        rst = 1'b0;
        #1;
        $display("seq async_reset_in_exec: out=%b cnt=%0d", out_vec, instr_count);
        chk("async_reset_out", {6'd0, out_vec}, {6'd0, V_HALT});
        chk("async_reset_cnt", {14'd0, instr_count}, 16'd0);

        @(negedge clk);
        rst = 1'b1; run = 1'b0; mem_ack = 1'b0; neg = 1'b0;
        @(negedge clk); #1;
        chk("post_reset_halt", {6'd0, out_vec}, {6'd0, V_HALT});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
